// File: rtl/hdmi_period_sched.sv
// HDMI pixel-clock period scheduler: delays raw sync/DE by 11 cycles and
// sequences video preamble/guard and data-island periods for the TMDS encoders.
module hdmi_period_sched #(
   parameter int MAX_PKTS = 18,
   parameter int LW       = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_de,
   input  logic       i_hsync,
   input  logic       i_vsync,
   input  logic       i_island_req,
   input  logic [4:0] i_island_pkts,
   output logic       o_de,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic [2:0] o_period,
   output logic [3:0] o_ctl,
   output logic       o_island_ack,
   output logic       o_island_abort,
   output logic [4:0] o_pkt_idx,
   output logic [4:0] o_sub_idx
);

   typedef enum logic [2:0] {
      CTRL     = 3'd0,
      VPRE     = 3'd1,
      VGUARD   = 3'd2,
      VIDEO    = 3'd3,
      DPRE     = 3'd4,
      DGUARD_L = 3'd5,
      DATA     = 3'd6,
      DGUARD_T = 3'd7
   } period_t;

   localparam int             DLY       = 11;
   localparam int             NW        = LW + 6;
   localparam logic [4:0]     MAXP      = 5'(MAX_PKTS);
   localparam logic [LW-1:0]  BLANK_MAX = {LW{1'b1}};

   logic [DLY-1:0] de_dly, hs_dly, vs_dly;
   logic           rise;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         de_dly <= '0;
         hs_dly <= '0;
         vs_dly <= '0;
      end else begin
         de_dly <= {de_dly[DLY-2:0], i_de};
         hs_dly <= {hs_dly[DLY-2:0], i_hsync};
         vs_dly <= {vs_dly[DLY-2:0], i_vsync};
      end
   end

   assign o_de    = de_dly[DLY-1];
   assign o_hsync = hs_dly[DLY-1];
   assign o_vsync = vs_dly[DLY-1];
   assign rise    = i_de & ~de_dly[0];

   // Length of the most recent raw blank; gates island grants on the next line.
   logic [LW-1:0] blank_cnt, l_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blank_cnt <= '0;
         l_prev    <= '0;
      end else if (rise) begin
         l_prev    <= blank_cnt;
         blank_cnt <= '0;
      end else if (!i_de && blank_cnt != BLANK_MAX) begin
         blank_cnt <= blank_cnt + 1'b1;
      end
   end

   logic [4:0]    pkts_clamp;
   logic [NW-1:0] need;
   logic          grant_ok;

   always_comb begin
      pkts_clamp = i_island_pkts;
      if (i_island_pkts == 5'd0)
         pkts_clamp = 5'd1;
      else if (i_island_pkts > MAXP)
         pkts_clamp = MAXP;
   end

   assign need     = NW'(38) + (NW'(pkts_clamp) << 5);
   assign grant_ok = i_island_req && (need <= NW'(l_prev));

   period_t    state, nxt;
   logic [2:0] cnt, cnt_n;
   logic [1:0] gcnt, gcnt_n;
   logic       arm, arm_n;
   logic [4:0] npk, npk_n;
   logic [4:0] pkt, pkt_n;
   logic [4:0] sub, sub_n;
   logic       ack_n, abort_n;
   logic [3:0] ctl_n;
   logic       in_video, in_island;

   assign in_video  = state inside {VPRE, VGUARD, VIDEO};
   assign in_island = state inside {DPRE, DGUARD_L, DATA, DGUARD_T};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= CTRL;
         cnt            <= '0;
         gcnt           <= '0;
         arm            <= 1'b0;
         npk            <= '0;
         pkt            <= '0;
         sub            <= '0;
         o_ctl          <= '0;
         o_island_ack   <= 1'b0;
         o_island_abort <= 1'b0;
      end else begin
         state          <= nxt;
         cnt            <= cnt_n;
         gcnt           <= gcnt_n;
         arm            <= arm_n;
         npk            <= npk_n;
         pkt            <= pkt_n;
         sub            <= sub_n;
         o_ctl          <= ctl_n;
         o_island_ack   <= ack_n;
         o_island_abort <= abort_n;
      end
   end

   assign o_period  = state;
   assign o_pkt_idx = pkt;
   assign o_sub_idx = sub;

   always_comb begin
      nxt     = state;
      cnt_n   = cnt;
      gcnt_n  = gcnt;
      arm_n   = arm;
      npk_n   = npk;
      pkt_n   = '0;
      sub_n   = '0;
      ack_n   = 1'b0;
      abort_n = 1'b0;
      ctl_n   = 4'b0000;

      case (state)
         CTRL: begin
            // Grant window opens on the 4th CTRL cycle after the delayed DE fall.
            if (arm) begin
               if (gcnt == 2'd0) begin
                  arm_n = 1'b0;
                  if (grant_ok) begin
                     nxt   = DPRE;
                     cnt_n = 3'd7;
                     npk_n = pkts_clamp;
                     ack_n = 1'b1;
                  end
               end else begin
                  gcnt_n = gcnt - 2'd1;
               end
            end
         end
         VPRE: begin
            if (cnt == 3'd0) begin
               nxt   = VGUARD;
               cnt_n = 3'd1;
            end else begin
               cnt_n = cnt - 3'd1;
            end
         end
         VGUARD: begin
            if (cnt == 3'd0)
               nxt = VIDEO;
            else
               cnt_n = cnt - 3'd1;
         end
         VIDEO: begin
            // Look one stage early so CTRL lands with the first o_de = 0 cycle.
            if (!de_dly[DLY-2]) begin
               nxt    = CTRL;
               arm_n  = 1'b1;
               gcnt_n = 2'd3;
            end
         end
         DPRE: begin
            if (cnt == 3'd0) begin
               nxt   = DGUARD_L;
               cnt_n = 3'd1;
            end else begin
               cnt_n = cnt - 3'd1;
            end
         end
         DGUARD_L: begin
            if (cnt == 3'd0)
               nxt = DATA;
            else
               cnt_n = cnt - 3'd1;
         end
         DATA: begin
            if (sub == 5'd31) begin
               if (pkt == npk - 5'd1) begin
                  nxt   = DGUARD_T;
                  cnt_n = 3'd1;
               end else begin
                  pkt_n = pkt + 5'd1;
               end
            end else begin
               pkt_n = pkt;
               sub_n = sub + 5'd1;
            end
         end
         DGUARD_T: begin
            if (cnt == 3'd0)
               nxt = CTRL;
            else
               cnt_n = cnt - 3'd1;
         end
         default: nxt = CTRL;
      endcase

      // Active video always wins; an island in flight is dropped.
      if (rise && !in_video) begin
         nxt     = VPRE;
         cnt_n   = 3'd7;
         arm_n   = 1'b0;
         pkt_n   = '0;
         sub_n   = '0;
         ack_n   = 1'b0;
         abort_n = in_island;
      end

      case (nxt)
         VPRE:    ctl_n = 4'b0001;
         DPRE:    ctl_n = 4'b0101;
         default: ctl_n = 4'b0000;
      endcase
   end

endmodule

// File: tb/tb_hdmi_period_sched.sv
// Randomized and directed bench for hdmi_period_sched against a time-offset
// schedule model (periods derived from rise/grant edge offsets).
module tb_hdmi_period_sched;
   localparam int MAXP = 18;
   localparam int LW   = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_de = 1'b0, i_hsync = 1'b0, i_vsync = 1'b0, i_island_req = 1'b0;
   logic [4:0] i_island_pkts = '0;
   logic       o_de, o_hsync, o_vsync, o_island_ack, o_island_abort;
   logic [2:0] o_period;
   logic [3:0] o_ctl;
   logic [4:0] o_pkt_idx, o_sub_idx;

   hdmi_period_sched #(.MAX_PKTS(MAXP), .LW(LW)) dut (
      .clk(clk), .rst(rst),
      .i_de(i_de), .i_hsync(i_hsync), .i_vsync(i_vsync),
      .i_island_req(i_island_req), .i_island_pkts(i_island_pkts),
      .o_de(o_de), .o_hsync(o_hsync), .o_vsync(o_vsync),
      .o_period(o_period), .o_ctl(o_ctl),
      .o_island_ack(o_island_ack), .o_island_abort(o_island_abort),
      .o_pkt_idx(o_pkt_idx), .o_sub_idx(o_sub_idx)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference schedule: each period is a function of the offset from the
   // accepted DE rise (k) or the island grant edge (g).
   bit qde[$], qhs[$], qvs[$];
   int t, mode, k, g, n, grant_due, lows, lprev;
   int e_per, e_ctl, e_pkt, e_sub, e_ack, e_abort;

   task automatic model_reset();
      qde.delete(); qhs.delete(); qvs.delete();
      for (int i = 0; i < 11; i++) begin
         qde.push_back(1'b0); qhs.push_back(1'b0); qvs.push_back(1'b0);
      end
      t = 0; mode = 0; k = 0; g = 0; n = 1; grant_due = -1; lows = 0; lprev = 0;
      e_per = 0; e_ctl = 0; e_pkt = 0; e_sub = 0; e_ack = 0; e_abort = 0;
   endtask

   task automatic model_step();
      int prevp, d, nc;
      bit rise;
      t++;
      qde.push_front(i_de);    void'(qde.pop_back());
      qhs.push_front(i_hsync); void'(qhs.pop_back());
      qvs.push_front(i_vsync); void'(qvs.pop_back());
      rise = qde[0] && !qde[1];
      prevp = e_per; e_ack = 0; e_abort = 0;
      if (rise && !(prevp >= 1 && prevp <= 3)) begin
         e_abort = (prevp >= 4) ? 1 : 0;
         mode = 1; k = t; grant_due = -1;
      end else if (mode == 0 && grant_due == t) begin
         grant_due = -1;
         nc = (i_island_pkts == 0) ? 1 : ((int'(i_island_pkts) > MAXP) ? MAXP : int'(i_island_pkts));
         if (i_island_req && (38 + 32 * nc <= lprev)) begin
            mode = 2; g = t; n = nc; e_ack = 1;
         end
      end
      if (rise) begin
         lprev = lows; lows = 0;
      end else if (!i_de && lows < (1 << LW) - 1) begin
         lows++;
      end
      e_pkt = 0; e_sub = 0; e_per = 0;
      if (mode == 1) begin
         d = t - k;
         if (d < 8) e_per = 1;
         else if (d < 10) e_per = 2;
         else if (qde[10]) e_per = 3;
         else begin mode = 0; grant_due = t + 4; end
      end else if (mode == 2) begin
         d = t - g;
         if (d < 8) e_per = 4;
         else if (d < 10) e_per = 5;
         else if (d < 10 + 32 * n) begin e_per = 6; e_pkt = (d - 10) / 32; e_sub = (d - 10) % 32; end
         else if (d < 12 + 32 * n) e_per = 7;
         else mode = 0;
      end
      e_ctl = (e_per == 1) ? 1 : ((e_per == 4) ? 5 : 0);
   endtask

   int n_ack, n_abort, n_data, max_pkt, max_sub;

   task automatic compare();
      chk("de",     32'(o_de),           32'(qde[10]));
      chk("hsync",  32'(o_hsync),        32'(qhs[10]));
      chk("vsync",  32'(o_vsync),        32'(qvs[10]));
      chk("period", 32'(o_period),       e_per);
      chk("ctl",    32'(o_ctl),          e_ctl);
      chk("ack",    32'(o_island_ack),   e_ack);
      chk("abort",  32'(o_island_abort), e_abort);
      chk("pkt",    32'(o_pkt_idx),      e_pkt);
      chk("sub",    32'(o_sub_idx),      e_sub);
   endtask

   task automatic tick();
      i_hsync = 1'($urandom_range(0, 1));
      i_vsync = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      if (o_island_ack) n_ack++;
      if (o_island_abort) n_abort++;
      if (o_period == 3'd6) n_data++;
      if (int'(o_pkt_idx) > max_pkt) max_pkt = int'(o_pkt_idx);
      if (int'(o_sub_idx) > max_sub) max_sub = int'(o_sub_idx);
   endtask

   task automatic run_line(input int blank, input int active, input bit req, input int pkts);
      i_island_req = req; i_island_pkts = 5'(pkts);
      n_ack = 0; n_abort = 0; n_data = 0; max_pkt = 0; max_sub = 0;
      i_de = 1'b0; repeat (blank) tick();
      i_de = 1'b1; repeat (active) tick();
      i_de = 1'b0;
   endtask

   task automatic rst_zero(input string tag);
      chk({tag, "_per"},   32'(o_period),       0);
      chk({tag, "_ctl"},   32'(o_ctl),          0);
      chk({tag, "_de"},    32'(o_de),           0);
      chk({tag, "_hs"},    32'(o_hsync),        0);
      chk({tag, "_ack"},   32'(o_island_ack),   0);
      chk({tag, "_abort"}, 32'(o_island_abort), 0);
      chk({tag, "_sub"},   32'(o_sub_idx),      0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      rst_zero("por");
      rst = 1'b0;

      run_line(100, 64, 1'b1, 2);   chk("l1_ack", n_ack, 0);
      run_line(100, 64, 1'b1, 2);   chk("pk2_noack", n_ack, 0);
      run_line(100, 64, 1'b1, 1);   chk("pk1_ack", n_ack, 1);
      chk("pk1_data", n_data, 32); chk("pk1_sub", max_sub, 31); chk("pk1_pkt", max_pkt, 0);
      run_line(80, 64, 1'b1, 0);    chk("pk0_ack", n_ack, 1); chk("pk0_pkt", max_pkt, 0);
      run_line(80, 64, 1'b1, 0);    chk("pk0_b80_ack", n_ack, 1);
      run_line(620, 32, 1'b1, 31);  chk("pk31_short", n_ack, 0);
      run_line(613, 32, 1'b1, 31);  chk("pk31_ack", n_ack, 1);
      chk("pk31_data", n_data, 576); chk("pk31_pkt", max_pkt, 17); chk("pk31_abort", n_abort, 0);
      run_line(200, 32, 1'b1, 31);  chk("pk31_613", n_ack, 0);
      run_line(200, 32, 1'b1, 1);   chk("b200_ack", n_ack, 1);
      run_line(60, 32, 1'b1, 4);    chk("ovl_ack", n_ack, 1); chk("ovl_abort", n_abort, 1);
      run_line(100, 32, 1'b0, 1);   chk("noreq_ack", n_ack, 0); chk("noreq_abort", n_abort, 0);

      // Asynchronous reset while VIDEO is on the outputs.
      i_de = 1'b0; repeat (50) tick();
      i_de = 1'b1; repeat (30) tick();
      chk("pre_rst_video", 32'(o_period), 3);
      #2 rst = 1'b1;
      #1 rst_zero("async");
      @(negedge clk);
      rst_zero("held");
      i_de = 1'b0;
      model_reset();
      rst = 1'b0;
      repeat (20) tick();
      run_line(100, 64, 1'b1, 1);   chk("post_rst_ack", n_ack, 0);

      for (int ln = 0; ln < 40; ln++) begin
         run_line($urandom_range(12, 700), $urandom_range(1, 150),
                  1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 31));
      end
      i_de = 1'b0; repeat (40) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hdmi_period_sched.md
# hdmi_period_sched

Pixel-clock scheduler sitting ahead of the TMDS encoders and the per-lane 10:1 serializers. It delays raw sync/DE by a fixed lookahead so it can insert the 8-cycle preamble and 2-cycle guard band before every active-video period. It also grants and sequences data-island periods (preamble, leading guard, N×32-cycle packets, trailing guard) inside horizontal blanking. The encoders use its period code and CTL bits to select each lane's 10-bit word.

## Interface
- MAX_PKTS, 18: maximum packets per island; i_island_pkts is clamped to this value.
- LW, 12: width of the blanking-length counter.
- clk  in  1  pixel clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_de, i_hsync, i_vsync  in  1 each  raw timing from the video timing generator.
- i_island_req  in  1  level; a packet payload is pending.
- i_island_pkts  in  5  packets requested (1..MAX_PKTS); 0 is treated as 1.
- o_de, o_hsync, o_vsync  out  1 each  raw inputs delayed by exactly 11 cycles.
- o_period  out  3  0 CTRL, 1 VPRE, 2 VGUARD, 3 VIDEO, 4 DPRE, 5 DGUARD_L, 6 DATA, 7 DGUARD_T.
- o_ctl  out  4  {CTL3..CTL0}: 4'b0001 in VPRE, 4'b0101 in DPRE, 4'b0000 otherwise.
- o_island_ack  out  1  one-cycle pulse on the first DPRE cycle.
- o_island_abort  out  1  one-cycle pulse when an island is truncated by video.
- o_pkt_idx  out  5  current packet index during DATA, 0 otherwise.
- o_sub_idx  out  5  cycle within the packet (0..31) during DATA, 0 otherwise.

## Operation
- Delay line: 11 registered stages each for de, hsync and vsync.
- Blank measurement: counter `blank_cnt` counts raw i_de low cycles and saturates at 2^LW−1. On a raw DE rise, `l_prev <= blank_cnt` and the counter clears. After reset `l_prev = 0`, so no island can be granted until one full blank has been measured.
- Video path:
  - A raw DE rise (i_de 0→1) while state is CTRL, DPRE, DGUARD_L, DATA or DGUARD_T starts VPRE(8) → VGUARD(2) → VIDEO.
  - If the rise arrives while an island state is active, the block pulses o_island_abort and the island is dropped.
  - A raw DE rise while in VPRE, VGUARD or VIDEO is ignored. This happens only with a blank shorter than 11 cycles, which violates spec.
  - VIDEO holds while o_de = 1. The first cycle with o_de = 0 is CTRL.
- Island grant:
  - An island-start counter is loaded on the o_de falling edge. On the 4th CTRL cycle after that edge, the block evaluates: i_island_req and 4 + 12 + 32·N + 12 + 10 <= l_prev, where N is the clamped i_island_pkts.
  - If true: the block latches N and enters DPRE(8) → DGUARD_L(2) → DATA(32·N) → DGUARD_T(2) → CTRL.
  - If false: no grant this line, and the request is re-evaluated on the next line.
- DATA counters: o_sub_idx counts 0..31 and wraps. o_pkt_idx increments on wrap. DATA exits after packet N−1, sub 31.
- At most one island per blanking interval. The block does not grant in vertical blanking lines, because the grant is keyed to the o_de fall.

## Timing
- If i_de first samples high at edge k:
  - o_period = VPRE for cycles k+1..k+8, with o_ctl = 0001.
  - o_period = VGUARD for k+9..k+10.
  - o_de = 1 and o_period = VIDEO from k+11.
- All outputs are registered. o_period, o_ctl, o_pkt_idx and o_sub_idx change in the same cycle.
- Island grant at cycle g:
  - o_island_ack = 1 and o_period = DPRE in cycle g, with DPRE lasting g..g+7.
  - DGUARD_L for g+8..g+9.
  - DATA for g+10..g+9+32N.
  - DGUARD_T for the following 2 cycles.
- Reset (asynchronous, any state): state CTRL; all outputs 0; delay line, counters and l_prev cleared.

## Test plan
- Reset mid-VIDEO: assert rst → all outputs 0 and o_period = 0 immediately. After release with i_de = 0, o_period stays 0.
- Single line with blank 100 and active 64: o_period = 1 for 8 cycles, 2 for 2, then 3 for exactly 64 cycles aligned with o_de; o_ctl = 0001 only during VPRE.
- Blank 100 per line, i_island_req = 1, pkts = 2: on the second line 38 + 64 = 102 > 100, so no grant. With pkts = 1: 70 <= 100 → ack; DPRE 8, DGUARD_L 2, DATA 32 (sub_idx 0..31, pkt_idx 0), DGUARD_T 2.
- pkts = 0 with blank 80 → treated as 1, grant, pkt_idx stays 0. pkts = 31 with MAX_PKTS = 18 → clamped to 18; no grant unless l_prev >= 614.
- Force island overlap by shortening blank to 60 after measuring 200: raw DE rise during DATA → o_island_abort pulse, VPRE begins the next cycle, VIDEO aligned with o_de.
- First line after reset with req = 1: no ack, since l_prev = 0. Check o_hsync/o_vsync equal the inputs delayed by 11 cycles throughout.
